// File: rtl/burst_fifo_filler.sv
// Streams a contiguous DDR region into the 64x64 read-data queue using burst reads.
// Queue space for each burst is reserved before the request goes out.
module burst_fifo_filler #(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 24,
  parameter int BURST_LEN  = 16,
  parameter int DEPTH      = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  num_words,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_burst_count,
  input  logic                  mem_wait_req,
  input  logic                  mem_valid,
  input  logic [63:0]           mem_data,
  output logic                  q_enq_valid,
  output logic [63:0]           q_enq_bits,
  input  logic [6:0]            q_count,
  output logic                  q_flush
);

  typedef enum logic [2:0] {IDLE, FLUSH, REQ, WAIT, DRAIN} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [LEN_WIDTH-1:0]  req_left;
  logic [LEN_WIDTH-1:0]  rsp_left;
  logic [LEN_WIDTH-1:0]  rsp_left_nxt;
  logic [6:0]            reserved;
  logic [6:0]            reserved_nxt;
  logic [7:0]            blen;
  logic [7:0]            blen_q;
  logic [7:0]            space_need;
  logic                  fits;
  logic                  accept;
  logic                  abort_q;
  logic                  done_set;
  logic                  load;
  logic                  issue;

  function automatic logic [7:0] clamp_burst(input logic [LEN_WIDTH-1:0] left);
    if (left < LEN_WIDTH'(BURST_LEN)) return 8'(left);
    return 8'(BURST_LEN);
  endfunction

  // Stray responses must never wrap the reservation count.
  function automatic logic [6:0] sat_dec(input logic [6:0] v, input logic dec);
    return (dec && v != 7'd0) ? v - 7'd1 : v;
  endfunction

  assign blen         = clamp_burst(req_left);
  assign space_need   = {1'b0, q_count} + {1'b0, reserved} + blen;
  assign fits         = space_need <= 8'(DEPTH);
  assign accept       = (state == REQ) && !mem_wait_req;
  assign rsp_left_nxt = (mem_valid && rsp_left != '0) ? rsp_left - LEN_WIDTH'(1) : rsp_left;
  assign reserved_nxt = sat_dec(reserved + (accept ? blen_q[6:0] : 7'd0), mem_valid);

  always_comb begin
    state_nxt = state;
    done_set  = 1'b0;
    load      = 1'b0;
    issue     = 1'b0;
    q_flush   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (num_words == '0) begin
            done_set = 1'b1;
          end else begin
            load      = 1'b1;
            state_nxt = FLUSH;
          end
        end
      end
      FLUSH: begin
        q_flush   = 1'b1;
        state_nxt = abort ? DRAIN : WAIT;
      end
      WAIT: begin
        if (abort) begin
          state_nxt = DRAIN;
        end else if (req_left != '0 && fits) begin
          issue     = 1'b1;
          state_nxt = REQ;
        end else if (rsp_left_nxt == '0) begin
          // Registered done lands in the cycle right after the last response.
          done_set  = 1'b1;
          state_nxt = IDLE;
        end
      end
      REQ: begin
        if (accept) state_nxt = (abort || abort_q) ? DRAIN : WAIT;
      end
      DRAIN: begin
        if (reserved == '0) begin
          q_flush   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      addr     <= '0;
      req_left <= '0;
      rsp_left <= '0;
      reserved <= '0;
      blen_q   <= '0;
      abort_q  <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      done     <= done_set;
      reserved <= reserved_nxt;
      // An abort seen while stalled is remembered until the request is accepted.
      abort_q  <= (state == REQ) && !accept && (abort || abort_q);
      if (issue) blen_q <= blen;
      if (load) begin
        addr     <= base_addr;
        req_left <= num_words;
        rsp_left <= num_words;
      end else begin
        rsp_left <= rsp_left_nxt;
        if (accept) begin
          addr     <= addr + ADDR_WIDTH'({blen_q, 3'b000});
          req_left <= req_left - LEN_WIDTH'(blen_q);
        end
      end
    end
  end

  assign busy            = (state != IDLE);
  assign mem_rd          = (state == REQ);
  assign mem_addr        = addr;
  assign mem_burst_count = blen_q;
  assign q_enq_valid     = mem_valid && (state != DRAIN) && !reset;
  assign q_enq_bits      = q_enq_valid ? mem_data : '0;

endmodule

// File: tb/tb_burst_fifo_filler.sv
// Directed bench for burst_fifo_filler: an Avalon memory / queue model plus hand-derived checks.
module tb_burst_fifo_filler;

  logic        clock;
  logic        reset;
  logic        start;
  logic        abort;
  logic [31:0] base_addr;
  logic [23:0] num_words;
  logic        busy;
  logic        done;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic [7:0]  mem_burst_count;
  logic        mem_wait_req;
  logic        mem_valid;
  logic [63:0] mem_data;
  logic        q_enq_valid;
  logic [63:0] q_enq_bits;
  logic [6:0]  q_count;
  logic        q_flush;

  burst_fifo_filler dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .base_addr(base_addr), .num_words(num_words), .busy(busy), .done(done),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_burst_count(mem_burst_count),
    .mem_wait_req(mem_wait_req), .mem_valid(mem_valid), .mem_data(mem_data),
    .q_enq_valid(q_enq_valid), .q_enq_bits(q_enq_bits), .q_count(q_count),
    .q_flush(q_flush)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Model knobs and statistics
  int          cyc = 0;
  int          occ = 0;
  int          extra = 0;
  bit          consume = 1'b1;
  bit          resp_en = 1'b1;
  int          wait_budget = 0;
  logic [31:0] exp_addr = '0;
  logic [31:0] rsp_q[$];
  int          enq_cnt, flush_cnt, done_cnt, rsp_cnt, rd_cycles;
  int          last_flush_cyc, last_rsp_cyc, max_qc;
  logic [31:0] b_addr[$];
  int          b_len[$];
  int          b_qc[$];

  // Memory slave and queue occupancy model
  initial begin
    logic o_enq, o_flush, o_stall;
    mem_wait_req = 1'b0;
    mem_valid    = 1'b0;
    mem_data     = '0;
    q_count      = '0;
    forever begin
      @(negedge clock);
      cyc++;
      o_enq   = q_enq_valid;
      o_flush = q_flush;
      o_stall = mem_rd && mem_wait_req;
      if (!reset) begin
        if (q_enq_valid) begin
          chk("enq_data", q_enq_bits, {32'hDA7A_0000, exp_addr});
          exp_addr += 32'd8;
          enq_cnt++;
        end
        if (q_flush) begin flush_cnt++; last_flush_cyc = cyc; end
        if (done) done_cnt++;
        if (mem_valid) begin rsp_cnt++; last_rsp_cyc = cyc; end
        if (mem_rd) rd_cycles++;
        if (mem_rd && !mem_wait_req) begin
          b_addr.push_back(mem_addr);
          b_len.push_back(int'(mem_burst_count));
          b_qc.push_back(int'(q_count));
          for (int i = 0; i < int'(mem_burst_count); i++) rsp_q.push_back(mem_addr + 32'(8 * i));
        end
        if (int'(q_count) > max_qc) max_qc = int'(q_count);
      end
      @(posedge clock);
      #1;
      if (reset) begin
        rsp_q.delete();
        occ          = 0;
        wait_budget  = 0;
        mem_valid    = 1'b0;
        mem_wait_req = 1'b0;
        q_count      = '0;
      end else begin
        if (o_flush) occ = 0;
        if (consume && occ > 0) occ--;
        if (o_enq) occ++;
        if (o_stall && wait_budget > 0) wait_budget--;
        mem_wait_req = (wait_budget > 0);
        if (resp_en && rsp_q.size() > 0) begin
          mem_valid = 1'b1;
          mem_data  = {32'hDA7A_0000, rsp_q.pop_front()};
        end else begin
          mem_valid = 1'b0;
        end
        q_count = 7'(occ + extra);
      end
    end
  end

  task automatic to_drive();
    @(posedge clock);
    #2;
  endtask

  task automatic to_obs();
    @(negedge clock);
    #1;
  endtask

  task automatic clear_stats(input logic [31:0] first_addr);
    enq_cnt = 0; flush_cnt = 0; done_cnt = 0; rsp_cnt = 0; rd_cycles = 0;
    last_flush_cyc = 0; last_rsp_cyc = 0; max_qc = 0;
    b_addr.delete(); b_len.delete(); b_qc.delete();
    exp_addr = first_addr;
  endtask

  task automatic begin_xfer(input logic [31:0] b, input int n);
    to_drive();
    start     = 1'b1;
    base_addr = b;
    num_words = 24'(n);
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int k = 0;
    to_obs();
    while (busy && k < limit) begin
      to_obs();
      k++;
    end
    chk(tag, 64'(busy), 64'd0);
  endtask

  task automatic wait_first_burst(input string tag);
    int k = 0;
    while (b_addr.size() < 1 && k < 20) begin
      to_obs();
      k++;
    end
    chk(tag, 64'(b_addr.size()), 64'd1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; base_addr = '0; num_words = '0;
    to_obs();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rd", 64'(mem_rd), 64'd0);
    repeat (3) to_drive();
    reset = 1'b0;
    to_obs();
    chk("idle_done", 64'(done), 64'd0);
    chk("idle_flush", 64'(q_flush), 64'd0);
    chk("idle_enq", 64'(q_enq_valid), 64'd0);
    chk("idle_addr", 64'(mem_addr), 64'd0);
    chk("idle_blen", 64'(mem_burst_count), 64'd0);

    // Space-limited transfer: 30 foreign words held, consumer stopped
    extra = 30; consume = 1'b0;
    repeat (2) to_drive();
    clear_stats(32'h1000);
    begin_xfer(32'h1000, 40);
    for (int c = 0; c < 4; c++) begin
      if (c == 1) start = 1'b0;
      to_obs();
      case (c)
        0: begin chk("t1_c0_busy", 64'(busy), 64'd0); chk("t1_c0_flush", 64'(q_flush), 64'd0); end
        1: begin chk("t1_c1_flush", 64'(q_flush), 64'd1); chk("t1_c1_busy", 64'(busy), 64'd1);
                 chk("t1_c1_rd", 64'(mem_rd), 64'd0); end
        2: begin chk("t1_c2_flush", 64'(q_flush), 64'd0); chk("t1_c2_rd", 64'(mem_rd), 64'd0); end
        default: begin chk("t1_c3_rd", 64'(mem_rd), 64'd1); chk("t1_c3_addr", 64'(mem_addr), 64'h1000);
                 chk("t1_c3_blen", 64'(mem_burst_count), 64'd16); end
      endcase
      to_drive();
    end
    repeat (50) to_drive();
    to_obs();
    chk("t1_hold_bursts", 64'(b_addr.size()), 64'd2);
    chk("t1_b2_addr", 64'(b_addr[1]), 64'h1080);
    chk("t1_b2_len", 64'(b_len[1]), 64'd16);
    chk("t1_hold_qcount", 64'(q_count), 64'd62);
    chk("t1_hold_rsp", 64'(rsp_cnt), 64'd32);
    chk("t1_hold_busy", 64'(busy), 64'd1);
    to_drive();
    consume = 1'b1;
    wait_idle("t1_idle", 200);
    chk("t1_bursts", 64'(b_addr.size()), 64'd3);
    chk("t1_b3_addr", 64'(b_addr[2]), 64'h1100);
    chk("t1_b3_len", 64'(b_len[2]), 64'd8);
    chk("t1_b3_space", 64'(b_qc[2] <= 56), 64'd1);
    chk("t1_enq", 64'(enq_cnt), 64'd40);
    chk("t1_done", 64'(done_cnt), 64'd1);
    chk("t1_maxq", 64'(max_qc <= 64), 64'd1);

    // Five stall cycles on the only request
    to_drive();
    extra = 0; wait_budget = 5;
    repeat (2) to_drive();
    clear_stats(32'h3000);
    begin_xfer(32'h3000, 16);
    for (int c = 0; c < 10; c++) begin
      if (c == 1) start = 1'b0;
      to_obs();
      if (c >= 3 && c <= 8) begin
        chk("t2_rd", 64'(mem_rd), 64'd1);
        chk("t2_addr", 64'(mem_addr), 64'h3000);
        chk("t2_blen", 64'(mem_burst_count), 64'd16);
      end else if (c == 9) begin
        chk("t2_rd_end", 64'(mem_rd), 64'd0);
      end
      to_drive();
    end
    wait_idle("t2_idle", 100);
    chk("t2_bursts", 64'(b_addr.size()), 64'd1);
    chk("t2_rd_cycles", 64'(rd_cycles), 64'd6);
    chk("t2_enq", 64'(enq_cnt), 64'd16);
    chk("t2_done", 64'(done_cnt), 64'd1);

    // 100 words, consumer always ready
    to_drive();
    clear_stats(32'h2000);
    begin_xfer(32'h2000, 100);
    to_drive();
    start = 1'b0;
    wait_idle("t3_idle", 400);
    chk("t3_bursts", 64'(b_addr.size()), 64'd7);
    for (int i = 0; i < 7 && i < b_addr.size(); i++) begin
      chk("t3_baddr", 64'(b_addr[i]), 64'(32'h2000 + 32'(128 * i)));
      chk("t3_blen", 64'(b_len[i]), (i < 6) ? 64'd16 : 64'd4);
    end
    chk("t3_enq", 64'(enq_cnt), 64'd100);
    chk("t3_done", 64'(done_cnt), 64'd1);
    chk("t3_flush", 64'(flush_cnt), 64'd1);
    chk("t3_maxq", 64'(max_qc <= 64), 64'd1);

    // Abort with 16 words outstanding
    to_drive();
    resp_en = 1'b0;
    clear_stats(32'h4000);
    begin_xfer(32'h4000, 32);
    to_drive();
    start = 1'b0;
    wait_first_burst("t4_setup");
    begin
      int f0;
      to_drive();
      abort = 1'b1;
      to_drive();
      abort = 1'b0;
      f0 = flush_cnt;
      repeat (3) to_drive();
      to_obs();
      chk("t4_drain_busy", 64'(busy), 64'd1);
      chk("t4_drain_rd", 64'(mem_rd), 64'd0);
      to_drive();
      resp_en = 1'b1;
      wait_idle("t4_idle", 100);
      chk("t4_enq", 64'(enq_cnt), 64'd0);
      chk("t4_rsp", 64'(rsp_cnt), 64'd16);
      chk("t4_flush_once", 64'(flush_cnt - f0), 64'd1);
      chk("t4_flush_time", 64'(last_flush_cyc), 64'(last_rsp_cyc + 1));
      chk("t4_no_done", 64'(done_cnt), 64'd0);
      chk("t4_bursts", 64'(b_addr.size()), 64'd1);
    end

    // Zero-length transfer
    to_drive();
    clear_stats(32'h7000);
    begin_xfer(32'h7000, 0);
    to_obs();
    chk("t5_c0_done", 64'(done), 64'd0);
    to_drive();
    start = 1'b0;
    to_obs();
    chk("t5_c1_done", 64'(done), 64'd1);
    chk("t5_c1_busy", 64'(busy), 64'd0);
    to_drive();
    to_obs();
    chk("t5_c2_done", 64'(done), 64'd0);
    repeat (4) to_drive();
    to_obs();
    chk("t5_rd", 64'(rd_cycles), 64'd0);
    chk("t5_flush", 64'(flush_cnt), 64'd0);
    chk("t5_done_cnt", 64'(done_cnt), 64'd1);

    // Asynchronous reset while a request stalls and responses stream
    to_drive();
    clear_stats(32'h5000);
    begin_xfer(32'h5000, 32);
    to_drive();
    start = 1'b0;
    wait_first_burst("t6_setup");
    to_drive();
    wait_budget = 10;
    to_obs();
    to_drive();
    to_obs();
    chk("t6_pre_rd", 64'(mem_rd), 64'd1);
    chk("t6_pre_enq", 64'(q_enq_valid), 64'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("t6_rst_rd", 64'(mem_rd), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_enq", 64'(q_enq_valid), 64'd0);
    repeat (2) to_drive();
    reset = 1'b0;
    to_drive();
    clear_stats(32'h6000);
    begin_xfer(32'h6000, 16);
    to_drive();
    start = 1'b0;
    wait_idle("t6_idle", 100);
    chk("t6_bursts", 64'(b_addr.size()), 64'd1);
    if (b_addr.size() > 0) chk("t6_baddr", 64'(b_addr[0]), 64'h6000);
    chk("t6_enq", 64'(enq_cnt), 64'd16);
    chk("t6_done", 64'(done_cnt), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
